// File: rtl/sq_cxt_responder.sv
// SQ context-fetch responder: answers each ingress request with one egress beat
// carrying the stored per-QP context and a status code; keeps a saturating error count.
module sq_cxt_responder #(
    parameter int QP_NUM_LOG    = 8,
    parameter int IN_HEAD_WIDTH = 32,
    parameter int IN_DATA_WIDTH = 64,
    parameter int CXT_WIDTH     = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_cxt_ingress_valid,
    input  logic [IN_HEAD_WIDTH-1:0] fetch_cxt_ingress_head,
    input  logic [IN_DATA_WIDTH-1:0] fetch_cxt_ingress_data,
    input  logic                     fetch_cxt_ingress_start,
    input  logic                     fetch_cxt_ingress_last,
    output logic                     fetch_cxt_ingress_ready,
    output logic                     fetch_cxt_egress_valid,
    output logic [31:0]              fetch_cxt_egress_head,
    output logic [CXT_WIDTH-1:0]     fetch_cxt_egress_data,
    output logic                     fetch_cxt_egress_start,
    output logic                     fetch_cxt_egress_last,
    input  logic                     fetch_cxt_egress_ready,
    input  logic                     cxt_wr_en,
    input  logic [QP_NUM_LOG-1:0]    cxt_wr_addr,
    input  logic [CXT_WIDTH-1:0]     cxt_wr_data,
    input  logic                     cxt_wr_valid,
    output logic [15:0]              err_cnt
);
    localparam int DEPTH = 1 << QP_NUM_LOG;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [23:0]             qpn_q, qpn_d;
    logic                    ent_vld_q, ent_vld_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic                    eg_valid_q, eg_valid_d;
    logic [31:0]             eg_head_q, eg_head_d;
    logic [CXT_WIDTH-1:0]    eg_data_q, eg_data_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [CXT_WIDTH-1:0]    mem [DEPTH];
    logic [CXT_WIDTH-1:0]    rd_data_q;

    logic                    accept_s;
    logic                    rd_en_s;
    logic                    err_inc_s;
    logic [1:0]              status_s;
    logic [QP_NUM_LOG-1:0]   rd_addr_s;
    logic                    unused_s;

    assign fetch_cxt_ingress_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_DRAIN));
    assign accept_s  = fetch_cxt_ingress_valid & fetch_cxt_ingress_ready;
    assign rd_addr_s = fetch_cxt_ingress_head[QP_NUM_LOG-1:0];
    assign unused_s  = ^{fetch_cxt_ingress_data, fetch_cxt_ingress_head[27:24]};

    assign fetch_cxt_egress_valid = eg_valid_q;
    assign fetch_cxt_egress_start = eg_valid_q;
    assign fetch_cxt_egress_last  = eg_valid_q;
    assign fetch_cxt_egress_head  = eg_head_q;
    assign fetch_cxt_egress_data  = eg_data_q;
    assign err_cnt                = err_cnt_q;

    // Status priority: bad opcode, then out-of-range qpn, then invalid entry.
    always_comb begin
        if (op_q != 4'h1) begin
            status_s = 2'b11;
        end else if (qpn_q[23:QP_NUM_LOG] != {(24-QP_NUM_LOG){1'b0}}) begin
            status_s = 2'b10;
        end else if (!ent_vld_q) begin
            status_s = 2'b01;
        end else begin
            status_s = 2'b00;
        end
    end

    // Next-state, request capture, response formation and error counting.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        qpn_d      = qpn_q;
        ent_vld_d  = ent_vld_q;
        vld_d      = vld_q;
        eg_valid_d = eg_valid_q;
        eg_head_d  = eg_head_q;
        eg_data_d  = eg_data_q;
        rd_en_s    = 1'b0;
        err_inc_s  = 1'b0;

        if (cxt_wr_en) begin
            vld_d[cxt_wr_addr] = cxt_wr_valid;
        end else begin
            vld_d = vld_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s && fetch_cxt_ingress_start) begin
                    op_d      = fetch_cxt_ingress_head[31:28];
                    qpn_d     = fetch_cxt_ingress_head[23:0];
                    ent_vld_d = vld_q[rd_addr_s];
                    rd_en_s   = 1'b1;
                    state_d   = fetch_cxt_ingress_last ? ST_READ : ST_DRAIN;
                end else if (accept_s) begin
                    err_inc_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (accept_s && fetch_cxt_ingress_last) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_READ: begin
                eg_valid_d = 1'b1;
                eg_head_d  = {op_q, status_s, 2'b00, qpn_q};
                eg_data_d  = (status_s == 2'b00) ? rd_data_q : {CXT_WIDTH{1'b0}};
                err_inc_s  = status_s[1];
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (fetch_cxt_egress_ready) begin
                    eg_valid_d = 1'b0;
                    eg_head_d  = 32'h0000_0000;
                    eg_data_d  = {CXT_WIDTH{1'b0}};
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_inc_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 4'h0;
            qpn_q      <= 24'h00_0000;
            ent_vld_q  <= 1'b0;
            vld_q      <= {DEPTH{1'b0}};
            eg_valid_q <= 1'b0;
            eg_head_q  <= 32'h0000_0000;
            eg_data_q  <= {CXT_WIDTH{1'b0}};
            err_cnt_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            qpn_q      <= qpn_d;
            ent_vld_q  <= ent_vld_d;
            vld_q      <= vld_d;
            eg_valid_q <= eg_valid_d;
            eg_head_q  <= eg_head_d;
            eg_data_q  <= eg_data_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Context RAM; the read register samples the pre-write contents on a same-address write.
    always_ff @(posedge clk) begin
        if (cxt_wr_en) begin
            mem[cxt_wr_addr] <= cxt_wr_data;
        end
        if (rd_en_s) begin
            rd_data_q <= mem[rd_addr_s];
        end
    end
endmodule

// File: doc/sq_cxt_responder.md
# sq_cxt_responder

Responder end of the SQ context-fetch channel. Accepts context-fetch requests on an ingress head/data/start/last stream, looks up the per-QP SQ context in a local table, and returns one response beat on an egress stream. It sits in the queue subsystem as a lightweight context store in front of SQ metadata processing. A configuration write port loads and invalidates entries. The block also keeps a saturating error counter.

## Interface
Parameters:
- QP_NUM_LOG, 8: log2 of the table depth.
- IN_HEAD_WIDTH, 32: ingress head width.
- IN_DATA_WIDTH, 64: ingress data width; data is consumed and ignored.
- CXT_WIDTH, 128: context entry width, equal to the egress data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- fetch_cxt_ingress_valid  in  1  request beat valid.
- fetch_cxt_ingress_head  in  IN_HEAD_WIDTH  [31:28] opcode, [23:0] qpn.
- fetch_cxt_ingress_data  in  IN_DATA_WIDTH  ignored.
- fetch_cxt_ingress_start  in  1  first beat of a request.
- fetch_cxt_ingress_last  in  1  last beat of a request.
- fetch_cxt_ingress_ready  out  1  request beat accepted when valid and ready are both high.
- fetch_cxt_egress_valid  out  1  response valid.
- fetch_cxt_egress_head  out  32  [31:28] opcode echo, [27:26] status, [23:0] qpn echo; other bits 0.
- fetch_cxt_egress_data  out  CXT_WIDTH  context entry.
- fetch_cxt_egress_start  out  1  equals egress_valid (single-beat response).
- fetch_cxt_egress_last  out  1  equals egress_valid.
- fetch_cxt_egress_ready  in  1  downstream accept.
- cxt_wr_en  in  1  table write strobe.
- cxt_wr_addr  in  QP_NUM_LOG  entry index.
- cxt_wr_data  in  CXT_WIDTH  entry contents.
- cxt_wr_valid  in  1  valid bit written with the entry; 0 invalidates the entry.
- err_cnt  out  16  saturating error count.

## Operation
- Storage:
  - Context RAM: 2^QP_NUM_LOG x CXT_WIDTH, one synchronous read port, read-first on a same-address write.
  - Entry-valid bit array in flops.
- States and transitions:
  - IDLE: ready=1. On an accepted beat with start=1, latch opcode and qpn and issue the RAM read at qpn[QP_NUM_LOG-1:0].
    - If last=1, go to READ.
    - If last=0, go to DRAIN.
  - IDLE, stray beat: an accepted beat with start=0 is discarded, err_cnt increments, state stays IDLE.
  - DRAIN: ready=1. Accepted beats are discarded. The beat with last=1 moves the FSM to READ.
  - READ: ready=0. RAM data becomes available; the response is registered; go to RESP.
  - RESP: ready=0, egress_valid=1, head and data held stable. On egress_ready, go to IDLE.
- Status codes, evaluated in this priority order:
  - 2'b11 BAD_OP: opcode != 4'h1.
  - 2'b10 OUT_OF_RANGE: qpn[23:QP_NUM_LOG] != 0.
  - 2'b01 NOT_VALID: entry-valid bit clear.
  - 2'b00 OK.
- For any nonzero status, egress_data is forced to 0.
- err_cnt increments once per response with status BAD_OP or OUT_OF_RANGE, and once per stray beat. It saturates at 16'hFFFF.
- Config writes are accepted in every state and never stall.
  - A write to the address being read in the accept cycle returns the old data and old valid bit.
  - The write is visible to the next request.

## Timing
- Reset values: ingress_ready=0 while rst is asserted, then 1 in IDLE. egress_valid/start/last/head/data = 0. err_cnt=0. All valid bits = 0. State = IDLE.
- Latency: accept at cycle T (last=1), READ at T+1, egress_valid high at T+2.
- Throughput: one response per 3 cycles minimum, assuming egress_ready is held high.
- Backpressure: egress_valid stays high and head/data stay stable until egress_ready. Ingress is blocked from READ until the response handshake.
- Mid-operation reset: asynchronous return to IDLE. egress_valid drops immediately. Any pending request is lost.
- Counter width: 16 bits, no wrap.

## Test plan
- Write entry 5 = 128'hA5…A5 with cxt_wr_valid=1; send single-beat request opcode 1, qpn 5 -> egress at T+2 with head 32'h1000_0005, data A5…A5, start=last=1.
- Request qpn 0x000100 (QP_NUM_LOG=8) -> status 2'b10, data 0, err_cnt=1. Then request with opcode 4'h3 -> status 2'b11, err_cnt=2.
- Request for a never-written qpn 7 -> status 2'b01, err_cnt unchanged. Then write entry 7 with valid=0 and re-request -> status still 2'b01.
- 3-beat request (start, mid, last) -> ingress_ready=1 on all three beats, exactly one response. A standalone beat with start=0 -> discarded, err_cnt+1, no response.
- Hold egress_ready=0 for 10 cycles -> response stable throughout, ingress_ready=0. Release -> handshake, IDLE next cycle.
- Write entry 9 in the same cycle as the accept of a qpn-9 request -> old data returned; the next request returns new data. Assert rst while in RESP -> egress_valid=0 immediately, all entries invalid afterwards.
